thirty_two_bit_left_pad: RTL and testbench
==========================================

THIRTY_TWO_BIT_LEFT_PAD -- requirements
Module: thirty_two_bit_left_pad

Interface
REQ-001 Parameter IN_W, default 32, input data width.
REQ-002 Parameter OUT_W, default 64, output data width; SHALL satisfy OUT_W >= IN_W, else elaboration error.
REQ-003 clk  input  1  single clock; all sequential logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 a  input  IN_W  data word to pad.
REQ-006 out  output  OUT_W  combinational padded form of a.
REQ-007 in_valid  input  1  a is offered to the registered channel.
REQ-008 in_ready  output  1  registered channel can accept a.
REQ-009 out_q  output  OUT_W  registered padded word, head of 2-entry buffer.
REQ-010 out_valid  output  1  out_q holds a valid word.
REQ-011 out_ready  input  1  downstream accepts out_q.

Function
REQ-012 out SHALL equal {(OUT_W-IN_W) zero bits, a}: a in bits [IN_W-1:0], all upper bits 0, no clock dependency, valid during reset.
REQ-013 Registered channel SHALL be a 2-entry FIFO of padded words, same padding rule as out.
REQ-014 Input transfer when in_valid && in_ready at rising edge; output transfer when out_valid && out_ready.
REQ-015 in_ready SHALL be 1 when fewer than 2 entries held, or when 2 held and out_ready is 1 (simultaneous pop frees a slot).
REQ-016 Latency: word accepted at edge N SHALL appear on out_q with out_valid=1 after edge N when buffer was empty (1 cycle).
REQ-017 Simultaneous push and pop SHALL keep occupancy unchanged and preserve FIFO order.
REQ-018 Empty: out_valid=0, out_q holds last value (don't-care); pop ignored.
REQ-019 Full (2 entries, out_ready=0): in_ready=0; in_valid ignored, no data loss or overwrite.
REQ-020 out_q and out_valid SHALL be driven from registers only (no combinational path from a).
REQ-021 in_ready may depend combinationally on out_ready; no other in->out combinational path in the channel.

Reset
REQ-022 rst_n low SHALL immediately clear occupancy to 0, out_valid=0, out_q=0, pointers to 0.
REQ-023 Reset mid-operation SHALL discard all buffered words; in_ready=1 while in reset.
REQ-024 First edge after rst_n deasserts SHALL accept a transfer normally.

Configuration
REQ-025 Macro LEFT_PAD_SIGN_EXT_EN: when defined, an input port sign_ext (1 bit) SHALL exist; sign_ext=1 fills upper OUT_W-IN_W bits of out and of each pushed word with a[IN_W-1], sign_ext=0 fills zeros; sampled with a for the registered path.
REQ-026 Without LEFT_PAD_SIGN_EXT_EN: no sign_ext port; padding always zero.

Verification
REQ-027 a=0x00000000 -> out=0x0000000000000000.
REQ-028 a=0xFFFFFFFF -> out=0x00000000FFFFFFFF (macro off, or sign_ext=0); with macro on and sign_ext=1 -> 0xFFFFFFFFFFFFFFFF.
REQ-029 a=0xFF0000FF -> out=0x00000000FF0000FF.
REQ-030 Push 0x11111111, 0x22222222, 0x33333333 with out_ready=0 -> third blocked (in_ready=0); raise out_ready -> out_q 0x0000000011111111 then 0x0000000022222222, then 0x33333333 accepted and delivered in order.
REQ-031 Continuous in_valid=1, out_ready=1 -> one word per cycle, latency 1, in_ready stays 1.
REQ-032 Assert rst_n=0 with 2 entries buffered between edges -> out_valid=0 and out_q=0 immediately; after release, next push delivered correctly.

Source files
------------

// File: rtl/thirty_two_bit_left_pad_if.sv
// Bus bundle for the left-pad block: combinational pad path plus
// the valid/ready registered channel. sign_ext exists only with LEFT_PAD_SIGN_EXT_EN.
interface thirty_two_bit_left_pad_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 64
);
    logic [IN_W-1:0]  a;
    logic [OUT_W-1:0] out;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] out_q;
    logic             out_valid;
    logic             out_ready;
`ifdef LEFT_PAD_SIGN_EXT_EN
    logic             sign_ext;
`endif

    modport master (
        output a,
        output in_valid,
        output out_ready,
`ifdef LEFT_PAD_SIGN_EXT_EN
        output sign_ext,
`endif
        input  out,
        input  in_ready,
        input  out_q,
        input  out_valid
    );

    modport slave (
        input  a,
        input  in_valid,
        input  out_ready,
`ifdef LEFT_PAD_SIGN_EXT_EN
        input  sign_ext,
`endif
        output out,
        output in_ready,
        output out_q,
        output out_valid
    );
endinterface

// File: rtl/thirty_two_bit_left_pad.sv
// Pads an IN_W word up to OUT_W bits, combinationally and through a
// 2-entry FIFO. Optional macro LEFT_PAD_SIGN_EXT_EN selects sign fill via sign_ext.
module thirty_two_bit_left_pad #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 64
) (
    input logic                          clk,
    input logic                          rst_n,
    thirty_two_bit_left_pad_if.slave     bus
);

    if (OUT_W < IN_W) begin : g_bad_width
        $error("thirty_two_bit_left_pad: OUT_W must be >= IN_W");
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [OUT_W-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             fill;
    logic [OUT_W-1:0] padded;
    logic             push;
    logic             pop;

    function automatic logic [OUT_W-1:0] pad(
        input logic [IN_W-1:0] d,
        input logic            f
    );
        logic [OUT_W-1:0] r;
        r = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (i < IN_W) r[i] = d[i];
            else          r[i] = f;
        end
        return r;
    endfunction

`ifdef LEFT_PAD_SIGN_EXT_EN
    assign fill = bus.sign_ext & bus.a[IN_W-1];
`else
    assign fill = 1'b0;
`endif

    // Same padded word feeds the direct output and the FIFO write port
    assign padded = pad(bus.a, fill);
    assign bus.out = padded;

    assign bus.out_valid = (state != EMPTY);
    assign bus.out_q     = mem[rd_ptr];
    // A pop in the same cycle frees the slot a full buffer needs
    assign bus.in_ready  = (state != FULL) || bus.out_ready;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    // Occupancy state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nx;
    end

    // Next occupancy from push/pop
    always_comb begin
        state_nx = state;
        unique case (state)
            EMPTY: if (push) state_nx = ONE;
            ONE: begin
                if (push && !pop)      state_nx = FULL;
                else if (pop && !push) state_nx = EMPTY;
            end
            FULL: if (pop && !push) state_nx = ONE;
            default: state_nx = EMPTY;
        endcase
    end

    // Storage and pointers; reset clears everything so out_q reads 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= padded;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
        end
    end

endmodule

// File: tb/tb_thirty_two_bit_left_pad.sv
// Directed bench for thirty_two_bit_left_pad: vector table for the
// combinational pad, hand-written sequences for the FIFO channel.
module tb_thirty_two_bit_left_pad;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    thirty_two_bit_left_pad_if #(.IN_W(32), .OUT_W(64)) bus ();

    thirty_two_bit_left_pad #(.IN_W(32), .OUT_W(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        check(name, {63'd0, got}, {63'd0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        vecs[0] = '{32'h00000000, 64'h0000000000000000};
        vecs[1] = '{32'hFFFFFFFF, 64'h00000000FFFFFFFF};
        vecs[2] = '{32'hFF0000FF, 64'h00000000FF0000FF};
        vecs[3] = '{32'h80000000, 64'h0000000080000000};
        vecs[4] = '{32'h00000001, 64'h0000000000000001};
        vecs[5] = '{32'h7FFFFFFF, 64'h000000007FFFFFFF};

        rst_n = 1'b0;
        bus.a = 32'hFF0000FF;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
`ifdef LEFT_PAD_SIGN_EXT_EN
        bus.sign_ext = 1'b0;
`endif
        #12;
        check("rst_out_comb", bus.out, 64'h00000000FF0000FF);
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_q", bus.out_q, 64'h0);
        chk1("rst_in_ready", bus.in_ready, 1'b1);

        for (int i = 0; i < 6; i++) begin
            bus.a = vecs[i].a;
            #1;
            check($sformatf("pad_vec%0d", i), bus.out, vecs[i].exp);
        end

        @(negedge clk);
        rst_n = 1'b1;

        // Fill to full, third word blocked, then drain in order
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.a = 32'h11111111;
        #1;
        chk1("fill_rdy0", bus.in_ready, 1'b1);
        step();
        chk1("lat1_valid", bus.out_valid, 1'b1);
        check("lat1_q", bus.out_q, 64'h0000000011111111);
        @(negedge clk);
        bus.a = 32'h22222222;
        step();
        @(negedge clk);
        bus.a = 32'h33333333;
        #1;
        chk1("full_blocked", bus.in_ready, 1'b0);
        step();
        check("full_head", bus.out_q, 64'h0000000011111111);
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        chk1("full_pop_rdy", bus.in_ready, 1'b1);
        step();
        check("drain_q1", bus.out_q, 64'h0000000022222222);
        @(negedge clk);
        bus.in_valid = 1'b0;
        step();
        check("drain_q2", bus.out_q, 64'h0000000033333333);
        chk1("drain_v2", bus.out_valid, 1'b1);
        step();
        chk1("drain_empty", bus.out_valid, 1'b0);

        // Streaming: one word per cycle, latency 1
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.a = 32'hA0000000 + i;
            #1;
            chk1($sformatf("stream_rdy%0d", i), bus.in_ready, 1'b1);
            step();
            chk1($sformatf("stream_v%0d", i), bus.out_valid, 1'b1);
            check($sformatf("stream_q%0d", i), bus.out_q,
                  {32'h0, 32'hA0000000 + i});
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        step();
        chk1("stream_end", bus.out_valid, 1'b0);

        // Asynchronous reset with two words buffered
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.a = 32'hDEADBEEF;
        step();
        @(negedge clk);
        bus.a = 32'hCAFEF00D;
        step();
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk1("pre_rst_full", bus.in_ready, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk1("arst_valid", bus.out_valid, 1'b0);
        check("arst_q", bus.out_q, 64'h0);
        chk1("arst_rdy", bus.in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        bus.a = 32'h5A5A5A5A;
        step();
        chk1("post_rst_v", bus.out_valid, 1'b1);
        check("post_rst_q", bus.out_q, 64'h000000005A5A5A5A);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk1("post_rst_empty", bus.out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
